// File: rtl/w2_row_sched_if.sv
// Source-side row fetch stream for w2_row_sched.
// The source is the master: it drives src_valid/src_data and sees src_row/src_ready.
interface w2_row_sched_if #(
  parameter int DW = 16,
  parameter int RW = 8
);
  logic [RW-1:0] src_row;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;

  modport master (
    input  src_row,
    input  src_ready,
    output src_valid,
    output src_data
  );

  modport slave (
    output src_row,
    output src_ready,
    input  src_valid,
    input  src_data
  );
endinterface

// File: rtl/w2_row_sched.sv
// w2_row_sched: row scheduler for the layer-2 weight memory.
// Fetches NUM_ROWS rows of ROW_LEN words over a valid/ready stream, writes
// them into row banks and presents each filled bank to the MAC array.
// Build option: define W2_PINGPONG_EN for two alternating banks; left
// undefined, a single bank is used and fetch/consume never overlap.
module w2_row_sched #(
  parameter int NUM_ROWS = 200,
  parameter int ROW_LEN  = 10,
  parameter int DW       = 16,
  parameter int RW       = 8,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          weight2_loadNextRow,
  w2_row_sched_if.slave src,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [CW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          row_valid,
  output logic          rd_bank,
  input  logic          consume,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FILL,
    S_WAIT,
    S_DRAIN
  } state_t;

  // Row counters carry one extra bit so they can reach NUM_ROWS without wrapping.
  localparam logic [RW:0]   NR       = (RW+1)'(NUM_ROWS);
  localparam logic [CW-1:0] LAST_WRD = CW'(ROW_LEN - 1);

  state_t        state_q, state_d;
  logic [RW:0]   fetch_idx_q, fetch_idx_d;
  logic [RW:0]   cons_idx_q, cons_idx_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]    full_q, full_d;
  logic          rd_bank_q, rd_bank_d;
  logic [RW-1:0] src_row_q, src_row_d;
  logic          src_ready_q, src_ready_d;
  logic          ld_q, ld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_en_q, wr_en_d;
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic hs;
  logic last_word;
  logic fill_pend;
  logic cons_acc;
  logic fill_bank;
  logic next_bank;

  assign hs        = (state_q == S_FILL) && src_ready_q && src.src_valid;
  assign last_word = (word_cnt_q == LAST_WRD);
  // The full flag trails the last registered write by one cycle, so a bank
  // whose final word is still in the write register counts as occupied.
  assign fill_pend = wr_en_q && (wr_addr_q == LAST_WRD);
  assign cons_acc  = consume && row_valid;

`ifdef W2_PINGPONG_EN
  assign fill_bank = src_row_q[0];
  assign next_bank = fetch_idx_q[0];
`else
  assign fill_bank = 1'b0;
  assign next_bank = 1'b0;
`endif

  function automatic logic bank_free(input logic b);
    return !full_q[b] && !(fill_pend && (wr_bank_q == b));
  endfunction

  // Next-state logic for the fill FSM, bank flags, counters and outputs.
  always_comb begin
    state_d     = state_q;
    fetch_idx_d = fetch_idx_q;
    cons_idx_d  = cons_idx_q;
    word_cnt_d  = word_cnt_q;
    full_d      = full_q;
    rd_bank_d   = rd_bank_q;
    src_row_d   = src_row_q;
    done_d      = 1'b0;
    wr_en_d     = hs;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          state_d     = S_ISSUE;
          fetch_idx_d = '0;
          cons_idx_d  = '0;
          rd_bank_d   = 1'b0;
          full_d      = '0;
        end
      end
      S_ISSUE: begin
        word_cnt_d = '0;
        state_d    = S_FILL;
      end
      S_FILL: begin
        if (hs) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) begin
            fetch_idx_d = fetch_idx_q + 1'b1;
            if (fetch_idx_d == NR) begin
              state_d = S_DRAIN;
`ifdef W2_PINGPONG_EN
            end else if (bank_free(!fill_bank)) begin
              state_d = S_ISSUE;
`endif
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (bank_free(next_bank)) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (cons_idx_q == NR) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (hs) begin
      wr_bank_d = fill_bank;
      wr_addr_d = word_cnt_q;
      wr_data_d = src.src_data;
    end

    // Fill completion and consume touch different banks, so both may apply.
    if (fill_pend) full_d[wr_bank_q] = 1'b1;
    if (cons_acc) begin
      full_d[rd_bank_q] = 1'b0;
      cons_idx_d        = cons_idx_q + 1'b1;
`ifdef W2_PINGPONG_EN
      rd_bank_d         = !rd_bank_q;
`endif
    end

    ld_d = (state_d == S_ISSUE);
    if (state_d == S_ISSUE) src_row_d = fetch_idx_d[RW-1:0];
    src_ready_d = (state_d == S_FILL);
    busy_d      = (state_d != S_IDLE) || done_d;
  end

  // State and output registers; reset aborts any pass in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_idx_q <= '0;
      cons_idx_q  <= '0;
      word_cnt_q  <= '0;
      full_q      <= '0;
      rd_bank_q   <= 1'b0;
      src_row_q   <= '0;
      src_ready_q <= 1'b0;
      ld_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_idx_q <= fetch_idx_d;
      cons_idx_q  <= cons_idx_d;
      word_cnt_q  <= word_cnt_d;
      full_q      <= full_d;
      rd_bank_q   <= rd_bank_d;
      src_row_q   <= src_row_d;
      src_ready_q <= src_ready_d;
      ld_q        <= ld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign weight2_loadNextRow = ld_q;
  assign src.src_row         = src_row_q;
  assign src.src_ready       = src_ready_q;
  assign wr_en               = wr_en_q;
  assign wr_bank             = wr_bank_q;
  assign wr_addr             = wr_addr_q;
  assign wr_data             = wr_data_q;
  assign row_valid           = full_q[rd_bank_q];
  assign rd_bank             = rd_bank_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_w2_row_sched.sv
// Scoreboard bench for w2_row_sched: expected fetches and writes are queued
// when a pass is started, a monitor pops and compares them as the DUT emits
// weight2_loadNextRow / wr_en, while source and array models drive the inputs.
module tb_w2_row_sched;
  localparam int NUM_ROWS = 200;
  localparam int ROW_LEN  = 10;
  localparam int DW       = 16;
  localparam int RW       = 8;
  localparam int CW       = 4;
`ifdef W2_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef struct packed {
    logic          bank;
    logic [CW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          consume;
  logic          wld;
  logic          wr_en;
  logic          wr_bank;
  logic [CW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          row_valid;
  logic          rd_bank;
  logic          busy;
  logic          done;

  w2_row_sched_if #(.DW(DW), .RW(RW)) sif ();

  w2_row_sched #(
    .NUM_ROWS(NUM_ROWS),
    .ROW_LEN (ROW_LEN),
    .DW      (DW),
    .RW      (RW),
    .CW      (CW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .weight2_loadNextRow(wld),
    .src                (sif),
    .wr_en              (wr_en),
    .wr_bank            (wr_bank),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .row_valid          (row_valid),
    .rd_bank            (rd_bank),
    .consume            (consume),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  wr_t exp_wr_q[$];
  int  exp_row_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_ld, n_wr, n_cons, n_done;
  int  row_s, word_s;
  bit  src_en, src_tog, src_phase, cons_en;

  function automatic logic [DW-1:0] mk(input int r, input int w);
    return DW'(r * 256 + w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_pass(input int nrows);
    wr_t e;
    for (int r = 0; r < nrows; r++) begin
      exp_row_q.push_back(r);
      for (int w = 0; w < ROW_LEN; w++) begin
        e.bank = 1'(r % NB);
        e.addr = CW'(w);
        e.data = mk(r, w);
        exp_wr_q.push_back(e);
      end
    end
  endtask

  task automatic flush();
    exp_wr_q.delete();
    exp_row_q.delete();
    n_ld = 0; n_wr = 0; n_cons = 0; n_done = 0;
    row_s = 0; word_s = 0; src_phase = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ld"}, wld, 0);
    chk({tag, "_src_ready"}, sif.src_ready, 0);
    chk({tag, "_src_row"}, sif.src_row, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_bank"}, wr_bank, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_row_valid"}, row_valid, 0);
    chk({tag, "_rd_bank"}, rd_bank, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; cons_en = 1'b0; src_en = 1'b0; src_tog = 1'b0;
    consume = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flush();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic monitor();
    int  er;
    wr_t e;
    forever begin
      @(negedge clk);
      if (wld) begin
        if (exp_row_q.size() == 0) chk("ld_unexpected", 1, 0);
        else begin
          er = exp_row_q.pop_front();
          chk("src_row", sif.src_row, er);
          chk("ld_after_consume", (n_cons + NB - 1 >= er), 1);
        end
        n_ld++;
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_bank", wr_bank, e.bank);
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
        n_wr++;
      end
      if (consume && row_valid) begin
        chk("rd_bank_seq", rd_bank, (NB == 2) ? (n_cons % 2) : 0);
        n_cons++;
      end
      if (done) begin
        chk("busy_at_done", busy, 1);
        n_done++;
      end
    end
  endtask

  task automatic source();
    bit v;
    forever begin
      @(posedge clk); #1;
      if (!src_en) sif.src_valid = 1'b0;
      else begin
        v = src_tog ? !src_phase : 1'b1;
        src_phase = !src_phase;
        sif.src_valid = v;
        sif.src_data  = mk(row_s, word_s);
        if (v && sif.src_ready) begin
          word_s++;
          if (word_s == ROW_LEN) begin
            word_s = 0;
            row_s++;
          end
        end
      end
    end
  endtask

  task automatic consumer();
    forever begin
      @(posedge clk); #1;
      if (cons_en && row_valid) begin
        repeat (3) @(posedge clk);
        #1 consume = cons_en;
        @(posedge clk);
        #1 consume = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; consume = 1'b0;
    sif.src_valid = 1'b0; sif.src_data = '0;
    src_en = 1'b0; src_tog = 1'b0; cons_en = 1'b0;
    flush();
    fork
      monitor();
      source();
      consumer();
    join_none
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    reset = 1'b1;

    // Full pass, continuous source, array consumes a few cycles after row_valid.
    push_pass(NUM_ROWS);
    src_en = 1'b1; cons_en = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("start_ld_latency", wld, 1);
    chk("start_busy", busy, 1);
    @(negedge clk);
    chk("fill_src_ready", sif.src_ready, 1);
    chk("fill_ld_single", wld, 0);
    for (int i = 0; i < NUM_ROWS * 40 && n_done == 0; i++) @(negedge clk);
    chk("pass_done", n_done, 1);
    @(negedge clk);
    chk("pass_busy_low", busy, 0);
    chk("pass_done_pulse", done, 0);
    chk("pass_ld_count", n_ld, NUM_ROWS);
    chk("pass_wr_count", n_wr, NUM_ROWS * ROW_LEN);
    chk("pass_cons_count", n_cons, NUM_ROWS);
    chk("pass_exp_left", exp_wr_q.size() + exp_row_q.size(), 0);

    // Array never consumes: FSM parks once every bank is full.
    do_reset();
    push_pass(NB);
    src_en = 1'b1;
    pulse_start();
    repeat (200) @(negedge clk);
    chk("stall_ld_count", n_ld, NB);
    chk("stall_wr_count", n_wr, NB * ROW_LEN);
    chk("stall_src_ready", sif.src_ready, 0);
    chk("stall_row_valid", row_valid, 1);
    chk("stall_busy", busy, 1);

    // Toggling src_valid, plus stray consume and start during row 0.
    do_reset();
    push_pass(NUM_ROWS);
    src_tog = 1'b1; src_en = 1'b1; cons_en = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("stray_row_valid_low", row_valid, 0);
    @(posedge clk); #1 begin consume = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin consume = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("stray_rd_bank", rd_bank, 0);
    chk("stray_cons_count", n_cons, 0);
    chk("stray_busy", busy, 1);
    for (int i = 0; i < 1500 && n_cons < 3; i++) @(negedge clk);
    @(posedge clk); #1;
    chk("toggle_cons_reached", n_cons, 3);
    chk("toggle_rd_bank", rd_bank, (NB == 2) ? 1 : 0);

    // Reset in the middle of row 57's fill, then restart from row 0.
    do_reset();
    push_pass(NUM_ROWS);
    src_en = 1'b1; cons_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 6000 && !(n_ld == 58 && n_wr >= 57 * ROW_LEN + 3); i++) @(negedge clk);
    chk("row57_reached", (n_ld == 58 && n_wr >= 57 * ROW_LEN + 3), 1);
    @(posedge clk); #2 reset = 1'b0;
    #1 check_reset_vals("async");
    cons_en = 1'b0; src_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", n_done, 0);
    flush();
    @(posedge clk); #1 reset = 1'b1;
    push_pass(NUM_ROWS);
    src_en = 1'b1; cons_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 500 && !(n_ld >= 2 && n_cons >= 1); i++) @(negedge clk);
    chk("restart_progress", (n_ld >= 2 && n_cons >= 1), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
